// File: rtl/xpb_pkg.sv
// Shared types and elaboration helpers for the XPB lookup accumulator.
package xpb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Upper bounds for seg_slice operands; configurations must stay within them.
  localparam int unsigned SLICE_VEC_BITS = 4096;
  localparam int unsigned SLICE_SEG_BITS = 32;

  // Table depth for a given index width.
  function automatic int unsigned depth_of(input int unsigned seg_bits);
    return 32'd1 << seg_bits;
  endfunction

  // Counter width able to hold 0..num_segs.
  function automatic int unsigned segcnt_bits_of(input int unsigned num_segs);
    return $clog2(num_segs + 32'd1);
  endfunction

  // Extract segment k of a packed index vector.
  function automatic logic [SLICE_SEG_BITS-1:0] seg_slice(
    input logic [SLICE_VEC_BITS-1:0] vec,
    input int unsigned               k,
    input int unsigned               seg_bits
  );
    logic [SLICE_VEC_BITS-1:0] sh;
    logic [SLICE_SEG_BITS-1:0] mask;
    sh   = vec >> (k * seg_bits);
    mask = (SLICE_SEG_BITS'(1) << seg_bits) - SLICE_SEG_BITS'(1);
    return SLICE_SEG_BITS'(sh) & mask;
  endfunction

endpackage

// File: rtl/xpb_lut_accum_if.sv
// Index-in / sum-out valid-ready bus of the XPB lookup accumulator.
interface xpb_lut_accum_if #(
  parameter int unsigned IDX_BITS = 40,
  parameter int unsigned OUT_BITS = 1027
);

  logic                in_valid;
  logic                in_ready;
  logic [IDX_BITS-1:0] idx_in;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] sum_out;

  modport master (
    output in_valid,
    output idx_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum_out
  );

  modport slave (
    input  in_valid,
    input  idx_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum_out
  );

endinterface

// File: rtl/xpb_seg_ram.sv
// One runtime-programmable residue table: single write port, registered read,
// entry 0 always reads as zero.
module xpb_seg_ram
  import xpb_pkg::*;
#(
  parameter int unsigned WORD_BITS = 1024,
  parameter int unsigned SEG_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SEG_BITS-1:0]  waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [SEG_BITS-1:0]  raddr,
  output logic [WORD_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(SEG_BITS);

  logic [WORD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Index 0 is a hard zero, so whatever sits in mem[0] never matters.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= (raddr == '0) ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/xpb_lut_accum.sv
// Multi-segment XPB table lookup: one segment read per cycle, entries summed
// into a carry-preserving accumulator and handed off over valid/ready.
module xpb_lut_accum
  import xpb_pkg::*;
#(
  parameter int unsigned WORD_BITS = 1024,
  parameter int unsigned SEG_BITS  = 5,
  parameter int unsigned NUM_SEGS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  xpb_lut_accum_if.slave              bus,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_SEGS)-1:0] cfg_seg,
  input  logic [SEG_BITS-1:0]         cfg_idx,
  input  logic [WORD_BITS-1:0]        cfg_data,
  output logic                        cfg_err
);

  localparam int unsigned OUT_BITS    = WORD_BITS + $clog2(NUM_SEGS);
  localparam int unsigned IDX_BITS    = NUM_SEGS * SEG_BITS;
  localparam int unsigned SEL_BITS    = $clog2(NUM_SEGS);
  localparam int unsigned SEGCNT_BITS = segcnt_bits_of(NUM_SEGS);

  state_t                 state;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [OUT_BITS-1:0]    acc;
  logic [SEGCNT_BITS-1:0] seg_cnt;
  logic [IDX_BITS-1:0]    idx_q;
  logic                   rd_vld;
  logic [SEL_BITS-1:0]    rd_seg;

  logic [WORD_BITS-1:0]   rdata [NUM_SEGS];
  logic [WORD_BITS-1:0]   rd_word_c;
  logic                   cfg_ok_c;
  logic                   accept_c;
  logic                   issue_c;
  logic                   last_c;

  // Writes land only while idle and only on real (non-zero) entries.
  assign cfg_ok_c = cfg_we && (state == IDLE) && (cfg_idx != '0) &&
                    (32'(cfg_seg) < NUM_SEGS);
  assign accept_c = (state == IDLE) && in_ready_r && bus.in_valid;
  assign issue_c  = (state == RUN);
  assign last_c   = (seg_cnt == SEGCNT_BITS'(NUM_SEGS - 1));

  for (genvar k = 0; k < NUM_SEGS; k++) begin : g_seg
    xpb_seg_ram #(
      .WORD_BITS (WORD_BITS),
      .SEG_BITS  (SEG_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (cfg_ok_c && (cfg_seg == SEL_BITS'(k))),
      .waddr (cfg_idx),
      .wdata (cfg_data),
      .re    (issue_c && (seg_cnt == SEGCNT_BITS'(k))),
      .raddr (SEG_BITS'(seg_slice(SLICE_VEC_BITS'(idx_q), k, SEG_BITS))),
      .rdata (rdata[k])
    );
  end

  // Select the table whose read was launched last cycle.
  assign rd_word_c = rdata[rd_seg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      acc         <= '0;
      seg_cnt     <= '0;
      idx_q       <= '0;
      rd_vld      <= 1'b0;
      rd_seg      <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok_c;
      rd_vld  <= issue_c;
      rd_seg  <= SEL_BITS'(seg_cnt);
      if (rd_vld) begin
        acc <= acc + OUT_BITS'(rd_word_c);
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            idx_q      <= bus.idx_in;
            acc        <= '0;
            seg_cnt    <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          seg_cnt <= seg_cnt + 1'b1;
          if (last_c) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum_out   = acc;

endmodule

// File: doc/xpb_lut_accum.md
Name: xpb_lut_accum

Overview:
- Parametrised successor to the fixed, hardcoded single-segment XPB tables used in modular squaring reduction.
- Holds NUM_SEGS runtime-programmable tables of 2^SEG_BITS precomputed WORD_BITS-bit residues. Software loads them once per modulus.
- Accepts a packed index vector (the upper-bit segments of a square) and looks up one segment per cycle. Accumulates the selected entries into a single carry-preserving sum for the downstream reduction adder.
- Uses valid/ready handshakes on both sides.

Parameters:
- WORD_BITS, 1024, width of each table entry.
- SEG_BITS, 5, index width per segment; table depth is 2^SEG_BITS.
- NUM_SEGS, 8, number of segments/tables per operation.
- OUT_BITS, WORD_BITS+$clog2(NUM_SEGS), accumulator/result width (derived; must not be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  index vector valid
- in_ready  out  1  block can accept an index vector
- idx_in  in  NUM_SEGS*SEG_BITS  packed indices; segment k = bits [k*SEG_BITS +: SEG_BITS]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum_out  out  OUT_BITS  sum over k of table[k][idx_k]
- cfg_we  in  1  table write strobe
- cfg_seg  in  $clog2(NUM_SEGS)  table select
- cfg_idx  in  SEG_BITS  entry select
- cfg_data  in  WORD_BITS  entry value
- cfg_err  out  1  one-cycle pulse: write rejected

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: in_ready=0, out_valid=0, sum_out=0, cfg_err=0, FSM in IDLE, accumulator 0.
  - in_ready rises the first cycle after rst_n deasserts.
  - Table contents are NOT cleared by reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at cycle T, capture idx_in, clear acc, set seg_cnt=0, go to RUN.
  - RUN: cycles T+1..T+NUM_SEGS. Issue registered read of table[seg_cnt][idx_seg_cnt] and increment seg_cnt. Read data launched in cycle T+1+k is added to acc at the edge ending cycle T+2+k. After the last issue, go to DRAIN.
  - DRAIN: one cycle for the final add, then go to DONE.
  - DONE: out_valid=1 from cycle T+NUM_SEGS+2 and sum_out=acc, both held stable until out_ready. On out_valid&out_ready, go to IDLE with in_ready=1 the next cycle. There is no combinational ready path, so throughput is one operation per NUM_SEGS+3 cycles minimum.
- in_ready is 0 in RUN, DRAIN and DONE.
- Index 0 in any segment always contributes 0; storage for entry 0 is not required.
- Arithmetic: unsigned, zero-extended to OUT_BITS, never wraps; the worst case NUM_SEGS*(2^WORD_BITS-1) fits in OUT_BITS.
- Configuration writes:
  - Accepted only in IDLE and commit at that edge.
  - cfg_we in any other state, or with cfg_idx=0, or with cfg_seg>=NUM_SEGS: write dropped, cfg_err pulses the next cycle.
  - cfg_we in IDLE in the same cycle as an input accept: write commits and the operation observes the new value.
- Reset mid-operation (rst_n low in RUN/DRAIN/DONE): abort, with no out_valid for the aborted operation; the block returns to IDLE with previously written tables intact.
- in_valid while busy is ignored; the source must hold idx_in stable until accepted.

Decomposition:
- Package xpb_pkg: state enum (IDLE, RUN, DRAIN, DONE); localparams DEPTH=2^SEG_BITS, SEGCNT_BITS=$clog2(NUM_SEGS+1); helper function for the segment slice.
- Sub-module xpb_seg_ram: one per segment. Single write port, registered read port, forces read data 0 when the read index is 0.
- The top level contains the FSM, the read mux over segments, and the accumulator.

Test Plan (bench config: WORD_BITS=16, SEG_BITS=2, NUM_SEGS=4, OUT_BITS=18):
- Program table[s][i]=16'h0100*s+i for i=1..3, then idx_in=8'b11_10_01_00 accepted at T -> out_valid at T+6, sum_out=18'h00606.
- All entries 16'hFFFF, idx_in=8'hFF -> sum_out=18'h3FFFC (no overflow); idx_in=8'h00 -> sum_out=0.
- Hold out_ready=0 for 5 cycles after out_valid -> sum_out stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> in_ready=1 the next cycle.
- cfg_we during RUN with cfg_data=16'h1234 -> cfg_err pulse one cycle later, table unchanged (rerun gives the identical sum). Write with cfg_idx=0 -> cfg_err, zero contribution preserved.
- Input accept with a simultaneous write to table[2][2]=16'hABCD in IDLE -> result uses 16'hABCD.
- rst_n low for one cycle at T+3 -> out_valid never asserts for that operation, in_ready=1 after reset, and the next operation returns the correct sum using the old tables.
